// File: rtl/regfile_dump_if.sv
// Output beat stream of regfile_dump: one register value plus its index per
// valid/ready handshake.
interface regfile_dump_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;

    modport master (output out_valid, out_data, out_idx, input out_ready);
    modport slave  (input out_valid, out_data, out_idx, output out_ready);
endinterface

// File: rtl/regfile_dump.sv
// Walks a register index range through a spare register-file read port after the
// core halts and streams each (index, value) pair out over valid/ready.
module regfile_dump #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W-1:0]  first_idx,
    input  logic [IDX_W-1:0]  last_idx,
    input  logic              abort,
    output logic [IDX_W-1:0]  rd_idx,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    regfile_dump_if.master    out_if
);

    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cur_q, cur_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic              handshake;

    assign handshake = out_valid_q & out_if.out_ready;

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_d   = first_idx;
                    last_d  = last_idx;
                    state_d = (first_idx <= last_idx) ? READ : DONE;
                end
            end
            READ: begin
                out_data_d  = rd_data;
                out_idx_d   = cur_q;
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    if (cur_q == last_q) begin
                        state_d = DONE;
                    end else begin
                        cur_d   = cur_q + IDX_W'(1);
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // abort overrides everything, including a handshake in the same cycle
        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            cur_d       = cur_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign rd_idx           = cur_q;
    assign busy             = (state_q == READ) || (state_q == SEND);
    assign done             = (state_q == DONE);
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_idx   = out_idx_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: directed vector table, hand sequences for
// abort/reset/coherency, and randomized ranges against a queue-based model.
module tb_regfile_dump;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  first_idx;
    logic [4:0]  last_idx;
    logic        abort;
    logic [4:0]  rd_idx;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic [31:0] regs [32];

    int checks = 0;
    int errors = 0;

    regfile_dump_if #(.DATA_W(32), .IDX_W(5)) bus ();

    regfile_dump #(.DATA_W(32), .IDX_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .first_idx (first_idx),
        .last_idx  (last_idx),
        .abort     (abort),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .out_if    (bus)
    );

    // register file model: x0 reads as zero
    assign rd_data = (rd_idx == 5'd0) ? 32'd0 : regs[rd_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int f;
        int l;
        int stall;
        int hold;
        int mode;      // bit0: abort with start, bit1: start while busy, bit2: regfile writes mid-dump
        int beats;
        int done_cyc;  // -1: not checked
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expects to be entered at a negedge with the DUT idle; returns at a negedge, idle.
    task automatic do_dump(input int f, input int l, input int stall_pct, input int hold,
                           input int mode, input int exp_beats, input int exp_done_cyc,
                           input string name);
        logic [31:0] qd[$];
        int          qi[$];
        int          cyc, held, first_v, nb, nmodel;
        bit          fin, rdy;
        logic [31:0] v;
        nmodel = (f <= l) ? (l - f + 1) : 0;
        for (int i = f; i <= l; i++) begin
            qi.push_back(i);
            qd.push_back((i == 0) ? 32'd0 : regs[i]);
        end
        first_idx = 5'(f);
        last_idx  = 5'(l);
        start     = 1'b1;
        abort     = mode[0];
        bus.out_ready = 1'b0;
        cyc = 0; held = 0; first_v = -1; nb = 0; fin = 0;
        while (!fin && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            if (cyc == 1) begin
                chk({name, "_busy_c1"}, 32'(busy), 32'(nmodel > 0));
                if (mode[2] && l != 0 && qd.size() > 0) begin
                    regs[l] = 32'hC0FFEE00 ^ 32'(l);
                    qd[qd.size()-1] = regs[l];
                end
            end
            if (bus.out_valid) begin
                if (first_v < 0) first_v = cyc;
                chk({name, "_busy_send"}, 32'(busy), 32'd1);
                if (qi.size() == 0) begin
                    chk({name, "_extra_beat"}, 32'(bus.out_idx), 32'hFFFFFFFF);
                end else begin
                    chk({name, "_idx"}, 32'(bus.out_idx), 32'(qi[0]));
                    chk({name, "_data"}, bus.out_data, qd[0]);
                    if (mode[2] && qi[0] == l && l != 0) regs[l] = 32'hBAD0BAD0;
                end
                if (mode[1] && first_v == cyc) begin
                    start     = 1'b1;
                    first_idx = 5'd20;
                    last_idx  = 5'd20;
                end
                rdy = (held >= hold) && ($urandom_range(99) >= 32'(stall_pct));
                bus.out_ready = rdy;
                if (rdy) begin
                    if (qi.size() > 0) begin
                        void'(qi.pop_front());
                        v = qd.pop_front();
                    end
                    nb++;
                    held = 0;
                end else begin
                    held++;
                end
            end else begin
                bus.out_ready = 1'($urandom_range(1));
            end
            if (done) begin
                fin = 1;
                chk({name, "_left"}, 32'(qi.size()), 32'd0);
                chk({name, "_busy_done"}, 32'(busy), 32'd0);
                if (exp_done_cyc > 0) chk({name, "_done_cyc"}, 32'(cyc), 32'(exp_done_cyc));
            end
        end
        if (!fin) chk({name, "_timeout"}, 32'(cyc), 32'd0);
        chk({name, "_beats"}, 32'(nb), 32'(exp_beats));
        if (nmodel > 0) chk({name, "_first_valid"}, 32'(first_v), 32'd2);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({name, "_idle_done"}, 32'(done), 32'd0);
        chk({name, "_idle_busy"}, 32'(busy), 32'd0);
        chk({name, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int nv, f, l, st, hd, n;
        vecs[0] = '{f:5,  l:7,  stall:0, hold:0, mode:0, beats:3,  done_cyc:7};
        vecs[1] = '{f:10, l:10, stall:0, hold:4, mode:0, beats:1,  done_cyc:7};
        vecs[2] = '{f:0,  l:1,  stall:0, hold:0, mode:0, beats:2,  done_cyc:5};
        vecs[3] = '{f:9,  l:3,  stall:0, hold:0, mode:0, beats:0,  done_cyc:1};
        vecs[4] = '{f:31, l:31, stall:0, hold:0, mode:0, beats:1,  done_cyc:3};
        vecs[5] = '{f:0,  l:31, stall:0, hold:0, mode:0, beats:32, done_cyc:65};
        vecs[6] = '{f:4,  l:6,  stall:0, hold:1, mode:2, beats:3,  done_cyc:-1};
        vecs[7] = '{f:12, l:13, stall:0, hold:0, mode:1, beats:2,  done_cyc:5};
        vecs[8] = '{f:14, l:15, stall:0, hold:2, mode:4, beats:2,  done_cyc:-1};

        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[5] = 32'h11; regs[6] = 32'h22; regs[7] = 32'h33;
        regs[1] = 32'hDEADBEEF;

        rst = 1'b0; start = 1'b0; abort = 1'b0;
        first_idx = '0; last_idx = '0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_idx", 32'(rd_idx), 32'd0);
        chk("rst_data", bus.out_data, 32'd0);
        chk("rst_idx", 32'(bus.out_idx), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 32'd0);
        chk("idle_abort_done", 32'(done), 32'd0);

        for (int i = 0; i < 9; i++)
            do_dump(vecs[i].f, vecs[i].l, vecs[i].stall, vecs[i].hold, vecs[i].mode,
                    vecs[i].beats, vecs[i].done_cyc, $sformatf("vec%0d", i));

        // abort on the second beat of a full-range dump, with ready also high
        first_idx = 5'd0; last_idx = 5'd31; start = 1'b1; bus.out_ready = 1'b1;
        nv = 0;
        for (int c = 0; c < 20 && nv < 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus.out_valid) nv++;
        end
        chk("abort_reached", 32'(nv), 32'd2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        bus.out_ready = 1'b0;
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 3; c++) begin
            chk("abort_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        do_dump(2, 2, 0, 0, 0, 1, 3, "after_abort");

        // asynchronous reset while a beat is stalled
        first_idx = 5'd0; last_idx = 5'd31; start = 1'b1; bus.out_ready = 1'b0;
        nv = 0;
        for (int c = 0; c < 20 && nv < 1; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus.out_valid) nv++;
        end
        chk("rstmid_reached", 32'(nv), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_valid", 32'(bus.out_valid), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        chk("rstmid_rd_idx", 32'(rd_idx), 32'd0);
        chk("rstmid_data", bus.out_data, 32'd0);
        chk("rstmid_idx", 32'(bus.out_idx), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_no_done", 32'(done), 32'd0);
        do_dump(3, 4, 0, 0, 0, 2, 5, "after_rst");

        // randomized ranges, contents, and sink back-pressure
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            f  = int'($urandom_range(31));
            l  = int'($urandom_range(31));
            st = (it % 3 == 0) ? 0 : int'($urandom_range(60));
            hd = (it % 3 == 0) ? 0 : int'($urandom_range(2));
            n  = (f <= l) ? (l - f + 1) : 0;
            do_dump(f, l, st, hd, 0, n, (st == 0 && hd == 0) ? ((n == 0) ? 1 : 2 * n + 1) : -1,
                    $sformatf("rnd%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
